// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator and its downstream checker:
// word width, tap and corruption masks, injection FSM and corrupt-mode encodings.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    localparam logic [LFSR_W-1:0] TAP_MASK     = 8'h8C;
    localparam logic [LFSR_W-1:0] CORRUPT_MASK = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_INJECT = 2'd2
    } inj_state_e;

    typedef enum logic [1:0] {
        CM_OFF    = 2'b00,
        CM_SINGLE = 2'b01,
        CM_BURST  = 2'b10,
        CM_CONT   = 2'b11
    } corrupt_mode_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state function of the 8-bit LFSR, shared with the checker.
// The all-zero lower bits term folds state 8'h00 into the sequence (00 -> 8D).
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_next
);

    logic fb;

    always_comb begin
        fb     = i_state[LFSR_W-1] ^ (i_state[LFSR_W-2:0] == '0);
        o_next = {i_state[LFSR_W-2:0], fb} ^ (fb ? TAP_MASK : '0);
    end

endmodule

// File: rtl/lfsr_generator.sv
// 8-bit LFSR sequence generator with a valid-rate divider and seed reload.
// Error injection (FSM, burst counter, output mask) exists only under LFSR_GEN_ERR_INJ_EN.
module lfsr_generator
    import lfsr_pkg::*;
#(
    parameter logic [7:0] SEED      = 8'h01,
    parameter int          VALID_DIV = 1,
    parameter int          ERR_BURST = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_seed_load,
    input  logic [7:0] i_seed,
    input  logic [1:0] i_corrupt_mode,
    input  logic       i_corrupt_trigger,
    output logic [7:0] o_LFSR,
    output logic       o_valid
);

    localparam logic [7:0] DIV_LAST = 8'(VALID_DIV - 1);

    logic [LFSR_W-1:0] state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [7:0]        div_q, div_d;
    logic              valid_q, valid_d;
    logic [LFSR_W-1:0] step_next;
    logic [LFSR_W-1:0] corrupt_mask;
    logic              beat;

    lfsr_step u_step (
        .i_state (state_q),
        .o_next  (step_next)
    );

    // Seed reload wins over every other update and suppresses the beat.
    always_comb begin
        beat    = i_enable && !i_seed_load && (div_q == 8'd0);
        div_d   = div_q + 8'd1;
        if (i_seed_load || !i_enable || (div_q == DIV_LAST)) begin
            div_d = 8'd0;
        end
        state_d = state_q;
        if (i_seed_load) begin
            state_d = i_seed;
        end else if (beat) begin
            state_d = step_next;
        end
        valid_d = beat;
        lfsr_d  = beat ? (state_q ^ corrupt_mask) : lfsr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
            lfsr_q  <= '0;
            div_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            div_q   <= div_d;
            valid_q <= valid_d;
        end
    end

    assign o_LFSR  = lfsr_q;
    assign o_valid = valid_q;

`ifdef LFSR_GEN_ERR_INJ_EN

    localparam logic [3:0] BURST_LAST = 4'(ERR_BURST - 1);

    inj_state_e    fsm_q, fsm_d;
    corrupt_mode_e mode_q, mode_d;
    logic [3:0]    burst_q, burst_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= ST_IDLE;
            mode_q  <= CM_OFF;
            burst_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
        end
    end

    // The mode is latched on entry so a change mid-injection waits for the next entry.
    always_comb begin
        fsm_d   = fsm_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        if (i_seed_load) begin
            fsm_d   = ST_RUN;
            burst_d = 4'd0;
        end else if (i_enable) begin
            case (fsm_q)
                ST_IDLE: fsm_d = ST_RUN;
                ST_RUN: begin
                    if (i_corrupt_trigger && (i_corrupt_mode != CM_OFF)) begin
                        fsm_d   = ST_INJECT;
                        mode_d  = corrupt_mode_e'(i_corrupt_mode);
                        burst_d = 4'd0;
                    end
                end
                ST_INJECT: begin
                    if (beat) begin
                        case (mode_q)
                            CM_BURST: begin
                                if (burst_q == BURST_LAST) begin
                                    fsm_d   = ST_RUN;
                                    burst_d = 4'd0;
                                end else begin
                                    burst_d = burst_q + 4'd1;
                                end
                            end
                            CM_CONT: begin
                                if (!i_corrupt_trigger) begin
                                    fsm_d = ST_RUN;
                                end
                            end
                            default: fsm_d = ST_RUN;
                        endcase
                    end
                end
                default: fsm_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        corrupt_mask = (fsm_q == ST_INJECT) ? CORRUPT_MASK : '0;
    end

`else

    localparam int unused_err_burst = ERR_BURST;

    logic unused_inj;
    assign unused_inj = ^{i_corrupt_mode, i_corrupt_trigger};

    always_comb begin
        corrupt_mask = '0;
    end

`endif

endmodule
